// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encodings (common with the TAP controller),
// scan sequencer states and TMS walk constants.
package jtag_pkg;

  typedef enum logic [3:0] {
    test_logic_reset = 4'h0,
    run_test_idle    = 4'h1,
    select_dr_scan   = 4'h2,
    capture_dr       = 4'h3,
    shift_dr         = 4'h4,
    exit1_dr         = 4'h5,
    pause_dr         = 4'h6,
    exit2_dr         = 4'h7,
    update_dr        = 4'h8,
    select_ir_scan   = 4'h9,
    capture_ir       = 4'hA,
    shift_ir         = 4'hB,
    exit1_ir         = 4'hC,
    pause_ir         = 4'hD,
    exit2_ir         = 4'hE,
    update_ir        = 4'hF
  } tap_state_t;

  // Sequencer state names the TAP state reached on the next tck edge.
  typedef enum logic [3:0] {
    INIT, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RST_WALK, ERR
  } seq_state_t;

  localparam int   TLR_TMS_CNT = 5;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

endpackage

// File: rtl/jtag_shift_reg.sv
// Scan data holder: parallel-loaded shift-in word read out by bit index, and
// tdo capture into rdata one edge after the bit is presented.
module jtag_shift_reg
  import jtag_pkg::*;
#(
  parameter int MXLEN  = 32,
  parameter int MXLENB = 6,
  parameter int IDXW   = 5
) (
  input  logic              tck,
  input  logic              ntrst,
  input  logic              load,
  input  logic [MXLEN-1:0]  wdata,
  input  logic [MXLENB-1:0] len,
  input  logic              shift,
  input  logic [IDXW-1:0]   idx,
  input  logic              tdo,
  output logic              bit_out,
  output logic [MXLEN-1:0]  rdata
);

  logic [MXLEN-1:0] wreg;
  logic             cap_p1;
  logic [IDXW-1:0]  cap_idx_p1;

  always_ff @(posedge tck) begin
    if (load) wreg <= wdata;
    cap_idx_p1 <= idx;
  end

  assign bit_out = wreg[idx];

  // The TAP consumes the bit presented at edge k on edge k+1; tdo is sampled there.
  always_ff @(posedge tck or negedge ntrst) begin
    if (!ntrst) begin
      cap_p1 <= L;
      rdata  <= '0;
    end else begin
      cap_p1 <= shift;
      if (load) begin
        for (int i = 0; i < MXLEN; i++) begin
          if (i >= int'(len)) rdata[i] <= L;
        end
      end else if (cap_p1) begin
        rdata[cap_idx_p1] <= tdo;
      end
    end
  end

endmodule

// File: rtl/jtag_scan_seq.sv
// JTAG scan sequencer: walks the TAP from Run-Test/Idle through one IR or DR
// shift of 1..MXLEN bits and back, or through a five-TMS-high TAP reset.
module jtag_scan_seq
  import jtag_pkg::*;
#(
  parameter int MXLEN  = 32,
  parameter int MXLENB = 6
) (
  input  logic              tck,
  input  logic              ntrst,
  input  logic              start,
  input  logic              cmd_rst,
  input  logic              sel_ir,
  input  logic [MXLENB-1:0] len,
  input  logic [MXLEN-1:0]  wdata,
  input  logic              tdo,
  output logic              tms,
  output logic              tdi,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [MXLEN-1:0]  rdata
);

  localparam int                IDXW    = (MXLEN > 1) ? $clog2(MXLEN) : 1;
  localparam logic [MXLENB-1:0] LEN_MAX = MXLENB'(MXLEN);
  localparam logic [MXLENB-1:0] RST_CNT = MXLENB'(TLR_TMS_CNT - 1);
  localparam logic [MXLENB-1:0] ONE     = MXLENB'(1);

  seq_state_t        state;
  logic [MXLENB-1:0] cnt;
  logic [MXLENB-1:0] len_r;
  logic              ir_r;
  logic              len_bad;
  logic              accept;
  logic              shift_act;
  logic              bit_out;
  logic [MXLENB-1:0] bit_pos;

  assign len_bad   = (len == '0) || (len > LEN_MAX);
  assign accept    = (state == IDLE) && !busy && start && !cmd_rst && !len_bad;
  assign shift_act = (state == SHIFT);
  assign bit_pos   = len_r - cnt - ONE;

  jtag_shift_reg #(
    .MXLEN  (MXLEN),
    .MXLENB (MXLENB),
    .IDXW   (IDXW)
  ) u_shift (
    .tck     (tck),
    .ntrst   (ntrst),
    .load    (accept),
    .wdata   (wdata),
    .len     (len),
    .shift   (shift_act),
    .idx     (bit_pos[IDXW-1:0]),
    .tdo     (tdo),
    .bit_out (bit_out),
    .rdata   (rdata)
  );

  always_ff @(posedge tck or negedge ntrst) begin
    if (!ntrst) begin
      state <= INIT;
      tms   <= L;
      tdi   <= L;
      busy  <= H;
      done  <= L;
      err   <= L;
      cnt   <= '0;
      len_r <= '0;
      ir_r  <= L;
    end else begin
      done <= L;
      err  <= L;
      case (state)
        INIT: begin
          tms   <= L;
          busy  <= L;
          state <= IDLE;
        end
        IDLE: begin
          tms <= L;
          tdi <= L;
          // IDLE while still busy is the edge on which the TAP lands in Run-Test/Idle.
          if (busy) begin
            busy <= L;
            done <= H;
          end else if (cmd_rst) begin
            tms   <= H;
            busy  <= H;
            cnt   <= RST_CNT;
            state <= RST_WALK;
          end else if (start) begin
            busy <= H;
            if (len_bad) begin
              state <= ERR;
            end else begin
              tms   <= H;
              len_r <= len;
              ir_r  <= sel_ir;
              state <= SEL_DR;
            end
          end
        end
        SEL_DR: begin
          tms   <= ir_r;
          state <= ir_r ? SEL_IR : CAPTURE;
        end
        SEL_IR: begin
          tms   <= L;
          state <= CAPTURE;
        end
        CAPTURE: begin
          tms   <= L;
          cnt   <= len_r - ONE;
          state <= SHIFT;
        end
        SHIFT: begin
          tdi <= bit_out;
          tms <= (cnt == '0);
          if (cnt == '0) state <= EXIT1;
          else           cnt   <= cnt - ONE;
        end
        EXIT1: begin
          tms   <= H;
          tdi   <= L;
          state <= UPDATE;
        end
        UPDATE: begin
          tms   <= L;
          state <= IDLE;
        end
        RST_WALK: begin
          if (cnt == '0) begin
            tms   <= L;
            state <= IDLE;
          end else begin
            tms <= H;
            cnt <= cnt - ONE;
          end
        end
        ERR: begin
          done  <= H;
          err   <= H;
          busy  <= L;
          state <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_seq.sv
// Bench for jtag_scan_seq: a TAP controller model with tdo <= tdi loopback and a
// completion scoreboard checked by an independent done monitor.
module tb_jtag_scan_seq;

  logic        tck = 1'b0;
  logic        ntrst;
  logic        start, cmd_rst, sel_ir;
  logic [5:0]  len;
  logic [31:0] wdata;
  logic        tdo;
  logic        tms, tdi, busy, done, err;
  logic [31:0] rdata;
  logic [3:0]  tap;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  jtag_scan_seq #(.MXLEN(32), .MXLENB(6)) dut (
    .tck     (tck),
    .ntrst   (ntrst),
    .start   (start),
    .cmd_rst (cmd_rst),
    .sel_ir  (sel_ir),
    .len     (len),
    .wdata   (wdata),
    .tdo     (tdo),
    .tms     (tms),
    .tdi     (tdi),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .rdata   (rdata)
  );

  always #5 tck = ~tck;
  always @(posedge tck) cyc <= cyc + 1;

  function automatic logic [3:0] tap_nxt(input logic [3:0] s, input logic t);
    case (s)
      4'h0:    return t ? 4'h0 : 4'h1;
      4'h1:    return t ? 4'h2 : 4'h1;
      4'h2:    return t ? 4'h9 : 4'h3;
      4'h3:    return t ? 4'h5 : 4'h4;
      4'h4:    return t ? 4'h5 : 4'h4;
      4'h5:    return t ? 4'h8 : 4'h6;
      4'h6:    return t ? 4'h7 : 4'h6;
      4'h7:    return t ? 4'h8 : 4'h4;
      4'h8:    return t ? 4'h2 : 4'h1;
      4'h9:    return t ? 4'h0 : 4'hA;
      4'hA:    return t ? 4'hC : 4'hB;
      4'hB:    return t ? 4'hC : 4'hB;
      4'hC:    return t ? 4'hF : 4'hD;
      4'hD:    return t ? 4'hE : 4'hD;
      4'hE:    return t ? 4'hF : 4'hB;
      default: return t ? 4'h2 : 4'h1;
    endcase
  endfunction

  // TAP controller model sharing tck and ntrst.
  always @(posedge tck or negedge ntrst) begin
    if (!ntrst) begin
      tap <= 4'h0;
      tdo <= 1'b0;
    end else begin
      tap <= tap_nxt(tap, tms);
      tdo <= tdi;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Completion monitor: every done must match the oldest expected response.
  always @(negedge tck) begin
    if (ntrst === 1'b1 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'(cyc), 64'(-1));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("done_err", 64'(err), 64'(e.er));
        chk("done_rdata", 64'(rdata), 64'(e.rd));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge tck);
  endtask

  task automatic do_scan(input logic ir, input logic [5:0] l, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input bit poke);
    logic [3:0] path[$];
    exp_t e;
    int acc;
    path.push_back(4'h2);
    if (ir) begin
      path.push_back(4'h9); path.push_back(4'hA);
      for (int i = 0; i < l; i++) path.push_back(4'hB);
      path.push_back(4'hC); path.push_back(4'hF);
    end else begin
      path.push_back(4'h3);
      for (int i = 0; i < l; i++) path.push_back(4'h4);
      path.push_back(4'h5); path.push_back(4'h8);
    end
    path.push_back(4'h1);
    @(negedge tck);
    sel_ir = ir; len = l; wdata = wd; start = 1'b1;
    acc = cyc + 1;
    e.rd = exp_rd; e.er = 1'b0; e.cyc = acc + path.size();
    sbq.push_back(e);
    @(negedge tck);
    start = 1'b0;
    chk("tap_after_accept", 64'(tap), 64'h1);
    for (int k = 0; k < path.size(); k++) begin
      @(negedge tck);
      start = 1'b0;
      if (poke && k == 3) begin
        start = 1'b1; sel_ir = 1'b0; len = 6'd2; wdata = 32'hFFFF_FFFF;
      end
      chk($sformatf("tap_path_%0d", k), 64'(tap), 64'(path[k]));
    end
    start = 1'b0;
    chk("busy_after_scan", 64'(busy), 64'h0);
    chk("tdi_idle", 64'(tdi), 64'h0);
  endtask

  task automatic do_err(input logic [5:0] l, input logic [31:0] prev_rd);
    exp_t e;
    @(negedge tck);
    sel_ir = 1'b0; len = l; wdata = 32'h1234_5678; start = 1'b1;
    e.rd = prev_rd; e.er = 1'b1; e.cyc = cyc + 2;
    sbq.push_back(e);
    for (int k = 0; k < 3; k++) begin
      @(negedge tck);
      start = 1'b0;
      chk("err_tap_hold", 64'(tap), 64'h1);
      chk("err_tms_low", 64'(tms), 64'h0);
    end
  endtask

  initial begin
    logic [3:0] rpath[6];
    exp_t e;
    rpath = '{4'h2, 4'h9, 4'h0, 4'h0, 4'h0, 4'h1};
    ntrst = 1'b0; start = 1'b0; cmd_rst = 1'b0; sel_ir = 1'b0; len = '0; wdata = '0;

    // Reset state and INIT walk into Run-Test/Idle.
    idle(2);
    chk("rst_busy", 64'(busy), 64'h1);
    chk("rst_tms", 64'(tms), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    chk("rst_tap", 64'(tap), 64'h0);
    ntrst = 1'b1;
    @(negedge tck);
    chk("init_tap", 64'(tap), 64'h1);
    chk("init_busy", 64'(busy), 64'h0);
    chk("init_tms", 64'(tms), 64'h0);
    idle(2);

    do_scan(1'b0, 6'd8, 32'h0000_00A5, 32'h0000_004A, 1'b0);
    idle(2);
    do_scan(1'b1, 6'd4, 32'h0000_000C, 32'h0000_0008, 1'b1);
    idle(4);

    // TAP reset, issued together with a start that must lose.
    @(negedge tck);
    cmd_rst = 1'b1; start = 1'b1; sel_ir = 1'b0; len = 6'd8; wdata = 32'hFF;
    e.rd = 32'h8; e.er = 1'b0; e.cyc = cyc + 7;
    sbq.push_back(e);
    @(negedge tck);
    cmd_rst = 1'b0; start = 1'b0;
    chk("rst_walk_start_tap", 64'(tap), 64'h1);
    for (int k = 0; k < 6; k++) begin
      @(negedge tck);
      chk($sformatf("rst_walk_tap_%0d", k), 64'(tap), 64'(rpath[k]));
    end
    idle(2);

    do_err(6'd0, 32'h8);
    do_err(6'd33, 32'h8);
    idle(2);

    do_scan(1'b0, 6'd32, 32'h8000_0001, 32'h0000_0002, 1'b0);
    idle(2);

    // Abort a full-length scan in the middle of Shift-DR.
    @(negedge tck);
    sel_ir = 1'b0; len = 6'd32; wdata = 32'hDEAD_BEEF; start = 1'b1;
    @(negedge tck);
    start = 1'b0;
    idle(8);
    chk("abort_pre_tap", 64'(tap), 64'h4);
    #2 ntrst = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'h1);
    chk("abort_tms", 64'(tms), 64'h0);
    chk("abort_tap", 64'(tap), 64'h0);
    chk("abort_rdata", 64'(rdata), 64'h0);
    @(negedge tck);
    ntrst = 1'b1;
    @(negedge tck);
    chk("recover_tap", 64'(tap), 64'h1);
    chk("recover_busy", 64'(busy), 64'h0);
    idle(6);

    chk("scoreboard_empty", 64'(sbq.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
